// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared encodings for the multi-cycle cpu controller
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_RTYPE = 3'b001;
    localparam logic [2:0] OP_ADDI  = 3'b011;
    localparam logic [2:0] OP_LD    = 3'b100;
    localparam logic [2:0] OP_ST    = 3'b101;
    localparam logic [2:0] OP_BEQ   = 3'b110;
    localparam logic [2:0] OP_JUMP  = 3'b111;

    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_AND = 4'b0001;
    localparam logic [3:0] FN_NOT = 4'b0010;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    localparam logic [1:0] RES_ADD = 2'b00;
    localparam logic [1:0] RES_CMP = 2'b01;
    localparam logic [1:0] RES_AND = 2'b10;
    localparam logic [1:0] RES_NOT = 2'b11;

    typedef enum logic [3:0] {
        CLS_NOP,
        CLS_R_ADD,
        CLS_R_AND,
        CLS_R_NOT,
        CLS_ADDI,
        CLS_LD,
        CLS_ST,
        CLS_BEQ,
        CLS_JUMP
    } instr_class_t;

endpackage

// File: rtl/cpu_mc_ctrl_if.sv
// rtl/cpu_mc_ctrl_if.sv - datapath/memory handshake bundle of the cpu controller
interface cpu_mc_ctrl_if;
    logic [15:0] instruction;
    logic        alu_zero;
    logic        mem_ready;
    logic        halt_req;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        regwrite_enable;
    logic        mread_enable;
    logic        mwrite_enable;
    logic        memtoreg_sel;
    logic        imm_sel;
    logic        func_sel;
    logic [1:0]  result_sel;
    logic [2:0]  state;
    logic        busy;
    logic        illegal_op;
    logic [15:0] retired;

    modport master (
        output instruction, alu_zero, mem_ready, halt_req,
        input  ir_write, pc_write, pc_src, regwrite_enable, mread_enable,
               mwrite_enable, memtoreg_sel, imm_sel, func_sel, result_sel,
               state, busy, illegal_op, retired
    );

    modport slave (
        input  instruction, alu_zero, mem_ready, halt_req,
        output ir_write, pc_write, pc_src, regwrite_enable, mread_enable,
               mwrite_enable, memtoreg_sel, imm_sel, func_sel, result_sel,
               state, busy, illegal_op, retired
    );
endinterface

// File: rtl/cpu_ctrl_decode.sv
// rtl/cpu_ctrl_decode.sv - combinational instruction-class and legality decode
module cpu_ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [2:0]   opcode,
    input  logic [3:0]   funct,
    output instr_class_t iclass,
    output logic         illegal
);

    always_comb begin
        iclass  = CLS_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_NOP:   iclass = CLS_NOP;
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:  iclass = CLS_R_ADD;
                    FN_AND:  iclass = CLS_R_AND;
                    FN_NOT:  iclass = CLS_R_NOT;
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI:  iclass = CLS_ADDI;
            OP_LD:    iclass = CLS_LD;
            OP_ST:    iclass = CLS_ST;
            OP_BEQ:   iclass = CLS_BEQ;
            OP_JUMP:  iclass = CLS_JUMP;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_mc_ctrl.sv
// rtl/cpu_mc_ctrl.sv - multi-cycle cpu control FSM with halt parking and retire count
module cpu_mc_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    cpu_mc_ctrl_if.slave  bus
);

    state_t       state_q, state_d;
    logic [15:0]  ir_q;
    logic [15:0]  retired_q;
    instr_class_t iclass;
    logic         illegal;

    logic         ir_write, pc_write, regwrite_enable, mread_enable, mwrite_enable;
    logic         memtoreg_sel, imm_sel, func_sel, illegal_op;
    logic [1:0]   pc_src, result_sel;
    logic         alu_func, alu_imm;
    logic [1:0]   alu_res;
    logic         unused_ir_bits;

    // Immediate/offset fields feed the datapath directly, not the controller.
    assign unused_ir_bits = ^ir_q[12:4];

    cpu_ctrl_decode u_decode (
        .opcode  (ir_q[15:13]),
        .funct   (ir_q[3:0]),
        .iclass  (iclass),
        .illegal (illegal)
    );

    always_comb begin
        alu_func = 1'b0;
        alu_res  = RES_ADD;
        alu_imm  = 1'b0;
        case (iclass)
            CLS_R_AND:               alu_res = RES_AND;
            CLS_R_NOT:               alu_res = RES_NOT;
            CLS_ADDI, CLS_LD, CLS_ST: alu_imm = 1'b1;
            CLS_BEQ: begin
                alu_func = 1'b1;
                alu_res  = RES_CMP;
                alu_imm  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        pc_src          = PC_SRC_INC;
        regwrite_enable = 1'b0;
        mread_enable    = 1'b0;
        mwrite_enable   = 1'b0;
        memtoreg_sel    = 1'b0;
        imm_sel         = 1'b0;
        func_sel        = 1'b0;
        result_sel      = RES_ADD;
        illegal_op      = 1'b0;

        case (state_q)
            ST_FETCH: begin
                ir_write = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                if (illegal) begin
                    illegal_op = 1'b1;
                    pc_write   = 1'b1;
                    state_d    = ST_FETCH;
                end else if (iclass == CLS_NOP) begin
                    pc_write = 1'b1;
                    state_d  = ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                func_sel   = alu_func;
                result_sel = alu_res;
                imm_sel    = alu_imm;
                case (iclass)
                    CLS_BEQ: begin
                        pc_write = 1'b1;
                        pc_src   = bus.alu_zero ? PC_SRC_BRANCH : PC_SRC_INC;
                        state_d  = ST_FETCH;
                    end
                    CLS_JUMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JUMP;
                        state_d  = ST_FETCH;
                    end
                    CLS_LD, CLS_ST: state_d = ST_MEM;
                    default:        state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                func_sel      = alu_func;
                result_sel    = alu_res;
                imm_sel       = alu_imm;
                mread_enable  = (iclass == CLS_LD);
                mwrite_enable = (iclass == CLS_ST);
                if (bus.mem_ready) begin
                    if (iclass == CLS_ST) begin
                        pc_write = 1'b1;
                        state_d  = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                func_sel        = alu_func;
                result_sel      = alu_res;
                imm_sel         = alu_imm;
                regwrite_enable = 1'b1;
                pc_write        = 1'b1;
                memtoreg_sel    = (iclass == CLS_LD);
                state_d         = ST_FETCH;
            end
            ST_HALT: state_d = bus.halt_req ? ST_HALT : ST_FETCH;
            default: state_d = ST_FETCH;
        endcase

        // Park only at an instruction boundary; unused codes always recover to FETCH.
        if (state_q inside {ST_DECODE, ST_EXEC, ST_MEM, ST_WB} &&
            state_d == ST_FETCH && bus.halt_req)
            state_d = ST_HALT;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (ir_write)
                ir_q <= bus.instruction;
            if (pc_write)
                retired_q <= retired_q + 16'd1;
        end
    end

    assign bus.ir_write        = ir_write;
    assign bus.pc_write        = pc_write;
    assign bus.pc_src          = pc_src;
    assign bus.regwrite_enable = regwrite_enable;
    assign bus.mread_enable    = mread_enable;
    assign bus.mwrite_enable   = mwrite_enable;
    assign bus.memtoreg_sel    = memtoreg_sel;
    assign bus.imm_sel         = imm_sel;
    assign bus.func_sel        = func_sel;
    assign bus.result_sel      = result_sel;
    assign bus.illegal_op      = illegal_op;
    assign bus.state           = state_q;
    assign bus.busy            = (state_q != ST_HALT);
    assign bus.retired         = retired_q;

endmodule

// File: tb/tb_cpu_mc_ctrl.sv
// tb/tb_cpu_mc_ctrl.sv - scoreboard bench for the multi-cycle cpu controller
module tb_cpu_mc_ctrl;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    cpu_mc_ctrl_if bus();

    cpu_mc_ctrl dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [16:0] ctl;
        logic [15:0] ret;
        int          idx;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc_n    = 0;
    logic [15:0] model_ret = '0;
    exp_t        mon_e;
    logic [16:0] mon_got;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // {state, ir_write, pc_write, pc_src, regwrite, mread, mwrite, memtoreg, imm, func, result, illegal, busy}
    function automatic logic [16:0] mk(input logic [2:0] st, input logic irw, input logic pcw,
                                       input logic [1:0] src, input logic regw, input logic mr,
                                       input logic mw, input logic m2r, input logic imm,
                                       input logic func, input logic [1:0] res, input logic ill);
        return {st, irw, pcw, src, regw, mr, mw, m2r, imm, func, res, ill, st != S_H};
    endfunction

    always @(negedge clock) begin
        if (sb.size() > 0) begin
            mon_e   = sb.pop_front();
            mon_got = {bus.state, bus.ir_write, bus.pc_write, bus.pc_src, bus.regwrite_enable,
                       bus.mread_enable, bus.mwrite_enable, bus.memtoreg_sel, bus.imm_sel,
                       bus.func_sel, bus.result_sel, bus.illegal_op, bus.busy};
            check($sformatf("ctl@%0d", mon_e.idx), {15'b0, mon_got}, {15'b0, mon_e.ctl});
            check($sformatf("retired@%0d", mon_e.idx), {16'b0, bus.retired}, {16'b0, mon_e.ret});
        end
    end

    task automatic cyc(input logic [15:0] instr, input logic az, input logic mr,
                       input logic hr, input logic rst, input logic [16:0] ctl);
        exp_t e;
        bus.instruction = instr;
        bus.alu_zero    = az;
        bus.mem_ready   = mr;
        bus.halt_req    = hr;
        reset           = rst;
        e.ctl = ctl;
        e.ret = model_ret;
        e.idx = cyc_n;
        sb.push_back(e);
        cyc_n++;
        if (ctl[12]) model_ret = model_ret + 16'd1;
        if (rst)     model_ret = '0;
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] instr, input logic az, input int waits, input logic hr);
        logic [2:0]  op;
        logic [3:0]  fn;
        logic [15:0] junk;
        logic        func, imm, ill, ld, st;
        logic [1:0]  res;
        op   = instr[15:13];
        fn   = instr[3:0];
        junk = ~instr;
        func = '0;
        imm  = '0;
        res  = 2'b00;
        ld   = (op == 3'b100);
        st   = (op == 3'b101);
        ill  = (op == 3'b010) || (op == 3'b001 && fn > 4'd2);
        if (op == 3'b001 && fn == 4'd1) res = 2'b10;
        if (op == 3'b001 && fn == 4'd2) res = 2'b11;
        if (op == 3'b011 || ld || st) imm = '1;
        if (op == 3'b110) begin
            func = '1;
            res  = 2'b01;
            imm  = '1;
        end

        cyc(instr, az, '1, hr, '0, mk(S_F, '1, '0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0));
        if (ill || op == 3'b000) begin
            cyc(junk, az, '1, hr, '0, mk(S_D, '0, '1, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, ill));
        end else begin
            cyc(junk, az, '1, hr, '0, mk(S_D, '0, '0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0));
            if (op == 3'b110) begin
                cyc(junk, az, '1, hr, '0, mk(S_E, '0, '1, {1'b0, az}, '0, '0, '0, '0, imm, func, res, '0));
            end else if (op == 3'b111) begin
                cyc(junk, az, '1, hr, '0, mk(S_E, '0, '1, 2'b10, '0, '0, '0, '0, '0, '0, 2'b00, '0));
            end else begin
                cyc(junk, az, '1, hr, '0, mk(S_E, '0, '0, 2'b00, '0, '0, '0, '0, imm, func, res, '0));
                if (ld || st)
                    for (int w = 0; w <= waits; w++)
                        cyc(junk, az, w == waits, hr, '0,
                            mk(S_M, '0, st && (w == waits), 2'b00, '0, ld, st, '0, imm, func, res, '0));
                if (!st)
                    cyc(junk, az, '1, hr, '0, mk(S_W, '0, '1, 2'b00, '1, '0, '0, ld, imm, func, res, '0));
            end
        end
        if (hr) begin
            cyc(junk, az, '1, '1, '0, mk(S_H, '0, '0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0));
            cyc(junk, az, '1, '0, '0, mk(S_H, '0, '0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0));
        end
    endtask

    initial begin
        bus.instruction = '0;
        bus.alu_zero    = '0;
        bus.mem_ready   = '0;
        bus.halt_req    = '0;
        reset           = '1;
        repeat (2) @(posedge clock);
        #1;

        run_instr(16'h0000, '0, 0, '0);
        run_instr(16'h6481, '0, 0, '0);
        run_instr(16'h8583, '0, 3, '0);
        run_instr(16'hC983, '1, 0, '0);
        run_instr(16'hC983, '0, 0, '0);
        run_instr(16'hE005, '0, 0, '0);
        run_instr(16'h2000, '1, 0, '0);
        run_instr(16'h2001, '0, 0, '0);
        run_instr(16'h2002, '0, 0, '0);
        run_instr(16'h2003, '0, 0, '0);
        run_instr(16'h4000, '0, 0, '0);
        run_instr(16'hA502, '0, 2, '1);
        run_instr(16'hA502, '0, 0, '0);
        run_instr(16'h0000, '0, 0, '1);
        run_instr(16'h6481, '1, 0, '0);

        cyc(16'h8583, '0, '1, '0, '0, mk(S_F, '1, '0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0));
        cyc(16'h7A7C, '0, '0, '0, '0, mk(S_D, '0, '0, 2'b00, '0, '0, '0, '0, '0, '0, 2'b00, '0));
        cyc(16'h7A7C, '0, '0, '0, '0, mk(S_E, '0, '0, 2'b00, '0, '0, '0, '0, '1, '0, 2'b00, '0));
        cyc(16'h7A7C, '0, '0, '0, '0, mk(S_M, '0, '0, 2'b00, '0, '1, '0, '0, '1, '0, 2'b00, '0));
        cyc(16'h7A7C, '0, '0, '0, '1, mk(S_M, '0, '0, 2'b00, '0, '1, '0, '0, '1, '0, 2'b00, '0));
        run_instr(16'h0000, '0, 0, '0);

        @(negedge clock);
        #1;
        check("sb_drained", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
